// File: rtl/ff_chain_tester.sv
// Parallel flip-flop chain stress tester: pattern generator feeds N_CHAINS shift
// chains of DEPTH flops; a lock-stepped checker compares each chain's last stage.
module ff_chain_tester #(
    parameter int          N_CHAINS = 8,
    parameter int          DEPTH    = 64,
    parameter int          CNT_W    = 16,
    parameter logic [14:0] SEED     = 15'h7FFF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          mode,
    input  logic                inject,
    output logic                busy,
    output logic                primed,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [N_CHAINS-1:0] err_mask,
    output logic                fail,
    output logic [N_CHAINS-1:0] chain_tap
);

    localparam int FW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_CHECK
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [14:0]           gen_lfsr_q, gen_lfsr_d;
    logic                  gen_phase_q, gen_phase_d;
    logic [14:0]           chk_lfsr_q, chk_lfsr_d;
    logic                  chk_phase_q, chk_phase_d;
    logic [FW-1:0]         fill_cnt_q, fill_cnt_d;
    logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
    logic [N_CHAINS-1:0]   err_mask_q, err_mask_d;
    logic                  fail_q, fail_d;
    logic                  busy_q, busy_d;
    logic                  primed_q, primed_d;
    logic [DEPTH-1:0]      chain_q [N_CHAINS];
    logic [DEPTH-1:0]      chain_d [N_CHAINS];

    logic                  gen_bit;
    logic                  chk_bit;
    logic                  chan_in;
    logic [N_CHAINS-1:0]   mismatch;

    function automatic logic pat_bit(input logic [1:0] m, input logic [14:0] lfsr,
                                     input logic ph);
        logic b;
        case (m)
            2'd0:    b = lfsr[14];
            2'd1:    b = 1'b0;
            2'd2:    b = 1'b1;
            default: b = ph;
        endcase
        return b;
    endfunction

    // x^15 + x^14 + 1, Fibonacci form, shifting towards the MSB
    function automatic logic [14:0] lfsr_step(input logic [14:0] lfsr);
        return {lfsr[13:0], lfsr[14] ^ lfsr[13]};
    endfunction

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        gen_lfsr_d  = gen_lfsr_q;
        gen_phase_d = gen_phase_q;
        chk_lfsr_d  = chk_lfsr_q;
        chk_phase_d = chk_phase_q;
        fill_cnt_d  = fill_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_mask_d  = err_mask_q;
        chain_d     = chain_q;
        mismatch    = '0;
        chan_in     = 1'b0;
        gen_bit     = pat_bit(mode_q, gen_lfsr_q, gen_phase_q);
        chk_bit     = pat_bit(mode_q, chk_lfsr_q, chk_phase_q);

        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else if (start && !stop) begin
            state_d     = S_FILL;
            mode_d      = mode;
            gen_lfsr_d  = SEED;
            gen_phase_d = 1'b0;
            chk_lfsr_d  = SEED;
            chk_phase_d = 1'b0;
            fill_cnt_d  = '0;
            err_cnt_d   = '0;
            err_mask_d  = '0;
        end else if (state_q != S_IDLE) begin
            gen_lfsr_d  = lfsr_step(gen_lfsr_q);
            gen_phase_d = ~gen_phase_q;
            for (int unsigned c = 0; c < N_CHAINS; c++) begin
                chan_in = gen_bit ^ c[0] ^ ((c == 0) ? inject : 1'b0);
                chain_d[c] = {chain_q[c][DEPTH-2:0], chan_in};
            end

            if (state_q == S_FILL) begin
                fill_cnt_d = fill_cnt_q + FW'(1);
                if (fill_cnt_q == FW'(DEPTH - 1)) begin
                    state_d = S_CHECK;
                end
            end else begin
                chk_lfsr_d  = lfsr_step(chk_lfsr_q);
                chk_phase_d = ~chk_phase_q;
                for (int unsigned c = 0; c < N_CHAINS; c++) begin
                    mismatch[c] = chain_q[c][DEPTH-1] ^ chk_bit ^ c[0];
                end
                if (|mismatch) begin
                    err_cnt_d  = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
                    err_mask_d = err_mask_q | mismatch;
                end
            end
        end

        fail_d   = |err_mask_d;
        busy_d   = (state_d != S_IDLE);
        primed_d = (state_d == S_CHECK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            gen_lfsr_q  <= SEED;
            gen_phase_q <= 1'b0;
            chk_lfsr_q  <= SEED;
            chk_phase_q <= 1'b0;
            fill_cnt_q  <= '0;
            err_cnt_q   <= '0;
            err_mask_q  <= '0;
            fail_q      <= 1'b0;
            busy_q      <= 1'b0;
            primed_q    <= 1'b0;
            chain_q     <= '{default: '0};
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            gen_lfsr_q  <= gen_lfsr_d;
            gen_phase_q <= gen_phase_d;
            chk_lfsr_q  <= chk_lfsr_d;
            chk_phase_q <= chk_phase_d;
            fill_cnt_q  <= fill_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_mask_q  <= err_mask_d;
            fail_q      <= fail_d;
            busy_q      <= busy_d;
            primed_q    <= primed_d;
            chain_q     <= chain_d;
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < N_CHAINS; c++) begin
            chain_tap[c] = chain_q[c][DEPTH-1];
        end
    end

    assign busy     = busy_q;
    assign primed   = primed_q;
    assign err_cnt  = err_cnt_q;
    assign err_mask = err_mask_q;
    assign fail     = fail_q;

endmodule

// File: tb/tb_ff_chain_tester.sv
// Directed bench for ff_chain_tester: vector table over modes and fill boundary,
// then hand sequences for injection, saturation, stop/restart and async reset.
module tb_ff_chain_tester;

    logic        clk = 1'b0;
    logic        rst, start, stop, inject;
    logic [1:0]  mode;

    logic        busy, primed, fail;
    logic [15:0] err_cnt;
    logic [7:0]  err_mask, chain_tap;

    logic        busy4, primed4, fail4;
    logic [3:0]  err_cnt4;
    logic [7:0]  err_mask4, chain_tap4;

    int n_tests = 0;
    int n_fail  = 0;

    ff_chain_tester #(.N_CHAINS(8), .DEPTH(64), .CNT_W(16), .SEED(15'h7FFF)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .inject(inject),
        .busy(busy), .primed(primed), .err_cnt(err_cnt), .err_mask(err_mask),
        .fail(fail), .chain_tap(chain_tap)
    );

    ff_chain_tester #(.N_CHAINS(8), .DEPTH(64), .CNT_W(4), .SEED(15'h7FFF)) dut4 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .inject(inject),
        .busy(busy4), .primed(primed4), .err_cnt(err_cnt4), .err_mask(err_mask4),
        .fail(fail4), .chain_tap(chain_tap4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        int         k;
        logic       busy;
        logic       primed;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    // Pulse start at E0, then present a different mode that must be ignored.
    task automatic do_start(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        step();
        start = 1'b0;
        mode  = ~m;
    endtask

    function automatic logic prbs_bit(input int j);
        logic [14:0] l;
        logic        g;
        l = 15'h7FFF;
        g = 1'b0;
        for (int i = 1; i <= j; i++) begin
            g = l[14];
            l = {l[13:0], l[14] ^ l[13]};
        end
        return g;
    endfunction

    // Tap after edge E_k (k >= 64) holds the bit pushed at E_(k-63).
    function automatic logic [7:0] exp_tap(input logic [1:0] m, input int k);
        int   j;
        logic g;
        j = k - 63;
        case (m)
            2'd0:    g = prbs_bit(j);
            2'd1:    g = 1'b0;
            2'd2:    g = 1'b1;
            default: g = ((j - 1) % 2) == 1;
        endcase
        return g ? 8'h55 : 8'hAA;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'd0,   63, 1'b1, 1'b0};
        vecs[1]  = '{2'd0,   64, 1'b1, 1'b1};
        vecs[2]  = '{2'd0,   65, 1'b1, 1'b1};
        vecs[3]  = '{2'd0, 1000, 1'b1, 1'b1};
        vecs[4]  = '{2'd1,   63, 1'b1, 1'b0};
        vecs[5]  = '{2'd1,   64, 1'b1, 1'b1};
        vecs[6]  = '{2'd1,  300, 1'b1, 1'b1};
        vecs[7]  = '{2'd2,   63, 1'b1, 1'b0};
        vecs[8]  = '{2'd2,   64, 1'b1, 1'b1};
        vecs[9]  = '{2'd2,  300, 1'b1, 1'b1};
        vecs[10] = '{2'd3,   64, 1'b1, 1'b1};
        vecs[11] = '{2'd3,   65, 1'b1, 1'b1};
        vecs[12] = '{2'd3,  300, 1'b1, 1'b1};
        vecs[13] = '{2'd3,  301, 1'b1, 1'b1};
        vecs[14] = '{2'd0,  200, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; stop = 1'b0; inject = 1'b0; mode = 2'd0;
        steps(2);
        check("reset_busy",   32'(busy),      32'h0);
        check("reset_primed", 32'(primed),    32'h0);
        check("reset_cnt",    32'(err_cnt),   32'h0);
        check("reset_mask",   32'(err_mask),  32'h0);
        check("reset_fail",   32'(fail),      32'h0);
        check("reset_tap",    32'(chain_tap), 32'h0);
        rst = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'h0);

        for (int v = 0; v < 15; v++) begin
            do_start(vecs[v].mode);
            steps(vecs[v].k);
            check($sformatf("vec%0d_busy", v),   32'(busy),    32'(vecs[v].busy));
            check($sformatf("vec%0d_primed", v), 32'(primed),  32'(vecs[v].primed));
            check($sformatf("vec%0d_cnt", v),    32'(err_cnt), 32'h0);
            check($sformatf("vec%0d_fail", v),   32'(fail),    32'h0);
            if (vecs[v].k >= 64)
                check($sformatf("vec%0d_tap", v), 32'(chain_tap),
                      32'(exp_tap(vecs[v].mode, vecs[v].k)));
        end

        // Single inject at E200 surfaces at E264.
        do_start(2'd0);
        steps(199);
        inject = 1'b1;
        step();
        inject = 1'b0;
        steps(63);
        check("inj_before_cnt", 32'(err_cnt), 32'h0);
        step();
        check("inj_cnt",  32'(err_cnt),  32'h1);
        check("inj_mask", 32'(err_mask), 32'h01);
        check("inj_fail", 32'(fail),     32'h1);
        steps(100);
        check("inj_hold_cnt", 32'(err_cnt), 32'h1);

        // 40 injected pushes in CHECK: wide counter 40, narrow counter saturates.
        do_start(2'd0);
        check("sat_clear_cnt", 32'(err_cnt4), 32'h0);
        steps(70);
        inject = 1'b1;
        steps(40);
        inject = 1'b0;
        steps(100);
        check("sat_cnt16", 32'(err_cnt),   32'd40);
        check("sat_cnt4",  32'(err_cnt4),  32'hF);
        check("sat_mask4", 32'(err_mask4), 32'h01);
        check("sat_mask",  32'(err_mask),  32'h01);

        // Stop at E100 holds results and chains; restart clears and refills.
        do_start(2'd0);
        steps(9);
        inject = 1'b1;
        step();
        inject = 1'b0;
        steps(89);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_busy",   32'(busy),     32'h0);
        check("stop_primed", 32'(primed),   32'h0);
        check("stop_cnt",    32'(err_cnt),  32'h1);
        check("stop_mask",   32'(err_mask), 32'h01);
        steps(19);
        check("stop_hold_cnt", 32'(err_cnt),   32'h1);
        check("stop_hold_tap", 32'(chain_tap), 32'(exp_tap(2'd0, 99)));
        do_start(2'd0);
        check("restart_busy",   32'(busy),     32'h1);
        check("restart_primed", 32'(primed),   32'h0);
        check("restart_cnt",    32'(err_cnt),  32'h0);
        check("restart_mask",   32'(err_mask), 32'h0);
        check("restart_fail",   32'(fail),     32'h0);
        steps(63);
        check("restart_primed63", 32'(primed), 32'h0);
        step();
        check("restart_primed64", 32'(primed), 32'h1);
        steps(200);
        check("restart_stale_cnt", 32'(err_cnt), 32'h0);

        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("startstop_busy",   32'(busy),   32'h0);
        check("startstop_primed", 32'(primed), 32'h0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("startstop_idle_busy", 32'(busy), 32'h0);

        // Async reset between edges mid-CHECK.
        do_start(2'd0);
        steps(4);
        inject = 1'b1;
        step();
        inject = 1'b0;
        steps(75);
        check("arst_pre_cnt",    32'(err_cnt), 32'h1);
        check("arst_pre_primed", 32'(primed),  32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy",   32'(busy),      32'h0);
        check("arst_primed", 32'(primed),    32'h0);
        check("arst_cnt",    32'(err_cnt),   32'h0);
        check("arst_mask",   32'(err_mask),  32'h0);
        check("arst_fail",   32'(fail),      32'h0);
        check("arst_tap",    32'(chain_tap), 32'h0);
        check("arst_cnt4",   32'(err_cnt4),  32'h0);
        step();
        rst = 1'b0;
        steps(5);
        check("arst_after_busy", 32'(busy),    32'h0);
        check("arst_after_cnt",  32'(err_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
